// File: rtl/lss5_pkg.sv
// Shared encodings and defaults for the 5-bit LFSR pattern checker.
package lss5_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // History taps for s(n) = s(n-1) ^ s(n-2) ^ s(n-5); h[0] is the newest bit.
    localparam int TAP_A = 0;
    localparam int TAP_B = 1;
    localparam int TAP_C = 4;

    localparam logic [4:0] DEGEN_ZERO = 5'b00000;
    localparam logic [4:0] DEGEN_ONE  = 5'b11111;

    localparam int DEF_LOCK_CNT = 8;
    localparam int DEF_WIN      = 16;
    localparam int DEF_LOSS_THR = 4;
    localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/lss5_pred.sv
// 5-bit history register and next-bit predictor for the pattern checker.
// p and degen are combinational from the registered history; no backpressure.
module lss5_pred
    import lss5_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic shift,
    input  logic clr,
    input  logic nbit,
    output logic p,
    output logic degen
);

    logic [4:0] h;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
        end else if (clr) begin
            h <= '0;
        end else if (shift) begin
            h <= {h[3:0], nbit};
        end
    end

    assign p     = h[TAP_A] ^ h[TAP_B] ^ h[TAP_C];
    assign degen = (h == DEGEN_ZERO) || (h == DEGEN_ONE);

endmodule

// File: rtl/lss5b_chk.sv
// Self-synchronising BIST checker for the 5-bit LFSR pattern stream; outputs registered,
// one valid bit per cycle, din_vld low freezes all state (no backpressure toward the link).
module lss5b_chk
    import lss5_pkg::*;
#(
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int WIN      = DEF_WIN,
    parameter int LOSS_THR = DEF_LOSS_THR,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int PW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int EW = $clog2(LOSS_THR + 1);

    state_t        state;
    logic [2:0]    fill;
    logic [MW-1:0] match_cnt;
    logic [PW-1:0] win_pos;
    logic [EW-1:0] win_err;

    logic p;
    logic degen;
    logic mism;
    logic lose;
    logic h_shift;
    logic h_nbit;

    assign mism = din ^ p;
    assign lose = (state == LOCKED) && din_vld && mism && (win_err == EW'(LOSS_THR - 1));

    // While locked the predictor free-runs on its own output so a bad bit cannot pollute h.
    assign h_shift = din_vld && !lose;
    assign h_nbit  = (state == LOCKED) ? p : din;

    lss5_pred u_pred (
        .clk   (clk),
        .rst   (rst),
        .shift (h_shift),
        .clr   (lose),
        .nbit  (h_nbit),
        .p     (p),
        .degen (degen)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            fill      <= '0;
            match_cnt <= '0;
            win_pos   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err <= 1'b0;
            if (din_vld) begin
                unique case (state)
                    HUNT: begin
                        fill <= fill + 3'd1;
                        if (fill == 3'd4) begin
                            state <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (!mism && !degen) begin
                            match_cnt <= match_cnt + 1'b1;
                            if (match_cnt == MW'(LOCK_CNT - 1)) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                win_pos <= '0;
                                win_err <= '0;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (mism) begin
                            err <= 1'b1;
                            if (err_cnt != {CNT_W{1'b1}}) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end
                        if (lose) begin
                            state     <= HUNT;
                            locked    <= 1'b0;
                            fill      <= '0;
                            match_cnt <= '0;
                        end else if (win_pos == PW'(WIN - 1)) begin
                            win_pos <= '0;
                            win_err <= mism ? EW'(1) : '0;
                        end else begin
                            win_pos <= win_pos + 1'b1;
                            if (mism) begin
                                win_err <= win_err + 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
            // Clear has the last word so it beats a same-cycle increment.
            if (clr) begin
                err_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lss5b_chk.sv
// Scoreboard bench for lss5b_chk: a bit-level reference model pushes expected outputs per driven cycle.
module tb_lss5b_chk;

    localparam int LOCK_CNT = 8;
    localparam int WIN      = 16;
    localparam int LOSS_THR = 4;
    localparam int CNT_W    = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             din = 1'b0;
    logic             din_vld = 1'b0;
    logic             clr = 1'b0;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    lss5b_chk #(
        .LOCK_CNT (LOCK_CNT),
        .WIN      (WIN),
        .LOSS_THR (LOSS_THR),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .din_vld (din_vld),
        .clr     (clr),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             lck;
        logic             e;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    logic [13:0] gen_seq = 14'b1001_0000_1101_11;
    int          g = 0;

    // Reference model state.
    int   m_mode;          // 0 hunt, 1 sync, 2 locked
    int   m_fill, m_mc, m_wpos, m_werr;
    int   m_cnt;
    logic m_locked;
    logic acc[$];          // last accepted bits, newest at the back

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic gen_bit(input int idx);
        return gen_seq[13 - idx];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_fill = 0; m_mc = 0; m_wpos = 0; m_werr = 0;
        m_cnt = 0; m_locked = 1'b0;
        acc.delete();
    endtask

    task automatic model_bit(input logic b, output logic e);
        logic pr;
        logic deg;
        e = 1'b0;
        pr = 1'b0;
        deg = 1'b0;
        if (acc.size() == 5) begin
            pr  = acc[4] ^ acc[3] ^ acc[0];
            deg = (acc[0] == acc[1]) && (acc[1] == acc[2]) && (acc[2] == acc[3]) && (acc[3] == acc[4]);
        end
        case (m_mode)
            0: begin
                acc.push_back(b);
                m_fill++;
                if (m_fill == 5) m_mode = 1;
            end
            1: begin
                if (b == pr && !deg) m_mc++;
                else m_mc = 0;
                acc.push_back(b);
                if (m_mc == LOCK_CNT) begin
                    m_mode = 2; m_locked = 1'b1; m_wpos = 0; m_werr = 0;
                end
            end
            default: begin
                acc.push_back(pr);
                if (b != pr) begin
                    e = 1'b1;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    m_werr++;
                end
                if (m_werr == LOSS_THR) begin
                    m_mode = 0; m_locked = 1'b0; m_fill = 0; m_mc = 0;
                    acc.delete();
                end else if (m_wpos == WIN - 1) begin
                    m_wpos = 0;
                    m_werr = e ? 1 : 0;
                end else begin
                    m_wpos++;
                end
            end
        endcase
        while (acc.size() > 5) void'(acc.pop_front());
    endtask

    // Drive one cycle from a negedge, predict, then compare just after the rising edge.
    task automatic step(input logic b, input logic v, input logic c);
        exp_t x;
        exp_t got;
        logic e;
        din = b; din_vld = v; clr = c;
        e = 1'b0;
        if (v) model_bit(b, e);
        if (c) m_cnt = 0;
        x.lck = m_locked; x.e = e; x.cnt = CNT_W'(m_cnt);
        expq.push_back(x);
        @(posedge clk);
        #1;
        got.lck = locked; got.e = err; got.cnt = err_cnt;
        x = expq.pop_front();
        chk("out", 32'(got), 32'(x));
        @(negedge clk);
        din_vld = 1'b0; clr = 1'b0;
    endtask

    task automatic gen_step(input logic flip, input logic v, input logic c);
        if (v) begin
            step(gen_bit(g) ^ flip, 1'b1, c);
            g = (g + 1) % 14;
        end else begin
            step(~gen_bit(g), 1'b0, c);
        end
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) gen_step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_cnt"}, 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        expq.delete();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset("rst0");

        // Clean stream: lock on the 13th bit, then 200 error-free bits.
        clean(12);
        chk("pre_lock", 32'(locked), 32'd0);
        clean(1);
        chk("lock13", 32'(locked), 32'd1);
        clean(200);
        chk("clean_cnt", 32'(err_cnt), 32'd0);

        // Single flipped bit while locked.
        gen_step(1'b1, 1'b1, 1'b0);
        chk("single_err", 32'(err), 32'd1);
        clean(20);
        chk("single_cnt", 32'(err_cnt), 32'd1);
        chk("single_lock", 32'(locked), 32'd1);

        // Four errors in one window force loss of lock, then reacquire.
        do_reset("rst1");
        clean(13);
        for (int i = 0; i < 4; i++) gen_step(1'b1, 1'b1, 1'b0);
        chk("loss", 32'(locked), 32'd0);
        chk("loss_cnt", 32'(err_cnt), 32'd4);
        clean(12);
        chk("relock_early", 32'(locked), 32'd0);
        clean(1);
        chk("relock", 32'(locked), 32'd1);
        chk("relock_cnt", 32'(err_cnt), 32'd4);

        // Constant streams are degenerate and never lock.
        do_reset("rst2");
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0);
        chk("ones_lock", 32'(locked), 32'd0);
        do_reset("rst3");
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0);
        chk("zeros_lock", 32'(locked), 32'd0);
        chk("zeros_cnt", 32'(err_cnt), 32'd0);

        // Valid toggling every other cycle; invalid cycles carry wrong data.
        do_reset("rst4");
        for (int i = 0; i < 60; i++) gen_step(1'b0, logic'(i % 2), 1'b0);
        chk("gap_lock", 32'(locked), 32'd1);
        chk("gap_cnt", 32'(err_cnt), 32'd0);

        // Clear coinciding with an error: pulse fires, count ends at zero.
        do_reset("rst5");
        clean(13);
        for (int i = 0; i < 3; i++) gen_step(1'b1, 1'b1, 1'b0);
        clean(20);
        chk("cnt3", 32'(err_cnt), 32'd3);
        gen_step(1'b1, 1'b1, 1'b1);
        chk("clr_err", 32'(err), 32'd1);
        chk("clr_cnt", 32'(err_cnt), 32'd0);
        chk("clr_lock", 32'(locked), 32'd1);

        // Reset mid-stream with an error pulse in flight.
        clean(5);
        gen_step(1'b1, 1'b1, 1'b0);
        chk("pre_rst_err", 32'(err), 32'd1);
        do_reset("rst6");
        clean(13);
        chk("rst_relock", 32'(locked), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
